// File: rtl/apb_req_master.sv
// Valid/ready request to APB3 initiator.
// Issues one SETUP/ACCESS transfer per accepted request and returns a single
// response. A bounded ACCESS wait keeps a hung peripheral from stalling the requester.
module apb_req_master #(
  parameter int unsigned ADDR_WIDTH     = 32,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  // request side
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic                  req_write_i,
  input  logic [ADDR_WIDTH-1:0] req_addr_i,
  input  logic [DATA_WIDTH-1:0] req_wdata_i,
  // response side
  output logic                  rsp_valid_o,
  input  logic                  rsp_ready_i,
  output logic [DATA_WIDTH-1:0] rsp_rdata_o,
  output logic [1:0]            rsp_err_o,
  // APB side
  output logic                  psel_o,
  output logic                  penable_o,
  output logic                  pwrite_o,
  output logic [ADDR_WIDTH-1:0] paddr_o,
  output logic [DATA_WIDTH-1:0] pwdata_o,
  input  logic [DATA_WIDTH-1:0] prdata_i,
  input  logic                  pready_i,
  input  logic                  pslverr_i
);

  localparam int unsigned CntW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  // Counter value seen on the last permitted ACCESS cycle.
  localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT_CYCLES - 1);
  // Saturation point; the counter never wraps back to zero.
  localparam logic [CntW-1:0] CntSat  = CntW'(TIMEOUT_CYCLES);

  localparam logic [1:0] ErrOk      = 2'b00;
  localparam logic [1:0] ErrSlv     = 2'b01;
  localparam logic [1:0] ErrTimeout = 2'b10;

  typedef enum logic [1:0] {StIdle, StSetup, StAccess, StResp} state_e;

  state_e                state_q, state_d;
  logic [CntW-1:0]       cnt_q, cnt_d;
  logic                  psel_q, psel_d;
  logic                  penable_q, penable_d;
  logic                  pwrite_q, pwrite_d;
  logic [ADDR_WIDTH-1:0] paddr_q, paddr_d;
  logic [DATA_WIDTH-1:0] pwdata_q, pwdata_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
  logic [1:0]            rsp_err_q, rsp_err_d;

  assign req_ready_o = (state_q == StIdle);

  // Next-state and registered-output decode for the transfer FSM.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    psel_d      = psel_q;
    penable_d   = penable_q;
    pwrite_d    = pwrite_q;
    paddr_d     = paddr_q;
    pwdata_d    = pwdata_q;
    rsp_valid_d = rsp_valid_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    unique case (state_q)
      StIdle: begin
        if (req_valid_i) begin
          paddr_d   = req_addr_i;
          pwdata_d  = req_wdata_i;
          pwrite_d  = req_write_i;
          psel_d    = 1'b1;
          penable_d = 1'b0;
          state_d   = StSetup;
        end
      end
      StSetup: begin
        penable_d = 1'b1;
        cnt_d     = '0;
        state_d   = StAccess;
      end
      StAccess: begin
        if (pready_i) begin
          // A completing slave wins over a coincident timeout.
          psel_d      = 1'b0;
          penable_d   = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_err_d   = pslverr_i ? ErrSlv : ErrOk;
          rsp_rdata_d = (!pwrite_q && !pslverr_i) ? prdata_i : '0;
          state_d     = StResp;
        end else begin
          if (cnt_q != CntSat) begin
            cnt_d = cnt_q + 1'b1;
          end
          if ((TIMEOUT_CYCLES != 0) && (cnt_q == CntLast)) begin
            psel_d      = 1'b0;
            penable_d   = 1'b0;
            rsp_valid_d = 1'b1;
            rsp_err_d   = ErrTimeout;
            rsp_rdata_d = '0;
            state_d     = StResp;
          end
        end
      end
      StResp: begin
        if (rsp_ready_i) begin
          rsp_valid_d = 1'b0;
          state_d     = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      psel_q      <= 1'b0;
      penable_q   <= 1'b0;
      pwrite_q    <= 1'b0;
      paddr_q     <= '0;
      pwdata_q    <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= ErrOk;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      psel_q      <= psel_d;
      penable_q   <= penable_d;
      pwrite_q    <= pwrite_d;
      paddr_q     <= paddr_d;
      pwdata_q    <= pwdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign psel_o      = psel_q;
  assign penable_o   = penable_q;
  assign pwrite_o    = pwrite_q;
  assign paddr_o     = paddr_q;
  assign pwdata_o    = pwdata_q;
  assign rsp_valid_o = rsp_valid_q;
  assign rsp_rdata_o = rsp_rdata_q;
  assign rsp_err_o   = rsp_err_q;

endmodule

// File: tb/tb_apb_req_master.sv
// Directed bench for apb_req_master with an 8-cycle ACCESS timeout.
module tb_apb_req_master;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_write;
  logic [31:0] req_addr, req_wdata;
  logic        rsp_valid, rsp_ready;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_err;
  logic        psel, penable, pwrite;
  logic [31:0] paddr, pwdata, prdata;
  logic        pready, pslverr;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  apb_req_master #(
    .ADDR_WIDTH    (32),
    .DATA_WIDTH    (32),
    .TIMEOUT_CYCLES(8)
  ) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .req_valid_i(req_valid),
    .req_ready_o(req_ready),
    .req_write_i(req_write),
    .req_addr_i (req_addr),
    .req_wdata_i(req_wdata),
    .rsp_valid_o(rsp_valid),
    .rsp_ready_i(rsp_ready),
    .rsp_rdata_o(rsp_rdata),
    .rsp_err_o  (rsp_err),
    .psel_o     (psel),
    .penable_o  (penable),
    .pwrite_o   (pwrite),
    .paddr_o    (paddr),
    .pwdata_o   (pwdata),
    .prdata_i   (prdata),
    .pready_i   (pready),
    .pslverr_i  (pslverr)
  );

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst       = 1'b1;
    req_valid = 1'b0;
    req_write = 1'b0;
    req_addr  = '0;
    req_wdata = '0;
    rsp_ready = 1'b1;
    prdata    = '0;
    pready    = 1'b0;
    pslverr   = 1'b0;
    tick();
    tick();
    check("rst_psel", psel, 0);
    check("rst_penable", penable, 0);
    check("rst_pwrite", pwrite, 0);
    check("rst_paddr", paddr, 0);
    check("rst_pwdata", pwdata, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rsp_rdata", rsp_rdata, 0);
    check("rst_rsp_err", rsp_err, 0);
    check("rst_req_ready", req_ready, 1);
    rst = 1'b0;

    // Write, zero wait states.
    req_valid = 1'b1; req_write = 1'b1;
    req_addr  = 32'h1A10_4000; req_wdata = 32'hDEAD_BEEF;
    pready    = 1'b1;
    tick();
    req_valid = 1'b0;
    check("wr_setup_psel", psel, 1);
    check("wr_setup_penable", penable, 0);
    check("wr_paddr", paddr, 32'h1A10_4000);
    check("wr_pwdata", pwdata, 32'hDEAD_BEEF);
    check("wr_pwrite", pwrite, 1);
    check("wr_setup_req_ready", req_ready, 0);
    check("wr_setup_rsp_valid", rsp_valid, 0);
    tick();
    check("wr_access_psel", psel, 1);
    check("wr_access_penable", penable, 1);
    tick();
    check("wr_resp_psel", psel, 0);
    check("wr_resp_penable", penable, 0);
    check("wr_rsp_valid", rsp_valid, 1);
    check("wr_rsp_err", rsp_err, 2'b00);
    check("wr_rsp_rdata", rsp_rdata, 0);
    tick();
    check("wr_done_rsp_valid", rsp_valid, 0);
    check("wr_done_req_ready", req_ready, 1);

    // Read, three wait states, pready on the 4th ACCESS cycle.
    pready    = 1'b0;
    req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h1A10_1000;
    tick();
    req_valid = 1'b0;
    tick();
    for (int i = 1; i <= 4; i++) begin
      check($sformatf("rd_access%0d_psel", i), psel, 1);
      check($sformatf("rd_access%0d_penable", i), penable, 1);
      check($sformatf("rd_access%0d_paddr", i), paddr, 32'h1A10_1000);
      check($sformatf("rd_access%0d_req_ready", i), req_ready, 0);
      check($sformatf("rd_access%0d_rsp_valid", i), rsp_valid, 0);
      if (i == 4) begin
        pready = 1'b1; prdata = 32'h1234_5678;
      end
      tick();
    end
    pready = 1'b0; prdata = '0;
    check("rd_rsp_valid", rsp_valid, 1);
    check("rd_rsp_rdata", rsp_rdata, 32'h1234_5678);
    check("rd_rsp_err", rsp_err, 2'b00);
    check("rd_resp_psel", psel, 0);
    tick();
    check("rd_done_rsp_valid", rsp_valid, 0);

    // Slave error on a read.
    pready = 1'b1; pslverr = 1'b1; prdata = 32'hFFFF_FFFF;
    req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h1A10_2000;
    tick();
    req_valid = 1'b0;
    tick();
    tick();
    check("err_rsp_valid", rsp_valid, 1);
    check("err_rsp_err", rsp_err, 2'b01);
    check("err_rsp_rdata", rsp_rdata, 0);
    tick();
    pslverr = 1'b0; prdata = '0; pready = 1'b0;

    // Timeout: pready never rises, abort after exactly 8 ACCESS cycles.
    req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h1A10_3000;
    tick();
    req_valid = 1'b0;
    tick();
    for (int i = 1; i <= 8; i++) begin
      check($sformatf("to_access%0d_psel", i), psel, 1);
      check($sformatf("to_access%0d_rsp_valid", i), rsp_valid, 0);
      tick();
    end
    check("to_psel", psel, 0);
    check("to_penable", penable, 0);
    check("to_rsp_valid", rsp_valid, 1);
    check("to_rsp_err", rsp_err, 2'b10);
    check("to_rsp_rdata", rsp_rdata, 0);
    tick();

    // pready on the 8th ACCESS cycle beats the timeout.
    req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h1A10_3004;
    tick();
    req_valid = 1'b0;
    tick();
    for (int i = 1; i <= 8; i++) begin
      if (i == 8) begin
        pready = 1'b1; prdata = 32'hCAFE_0001;
      end
      tick();
    end
    pready = 1'b0; prdata = '0;
    check("to8_rsp_valid", rsp_valid, 1);
    check("to8_rsp_err", rsp_err, 2'b00);
    check("to8_rsp_rdata", rsp_rdata, 32'hCAFE_0001);
    tick();

    // Response back-pressure: response held, no new request taken.
    rsp_ready = 1'b0; pready = 1'b1;
    req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h1A10_5000; req_wdata = 32'h0000_00A5;
    tick();
    req_addr = 32'h1A10_6000; req_wdata = 32'h0000_005A;
    tick();
    tick();
    for (int i = 1; i <= 5; i++) begin
      check($sformatf("bp%0d_rsp_valid", i), rsp_valid, 1);
      check($sformatf("bp%0d_rsp_err", i), rsp_err, 2'b00);
      check($sformatf("bp%0d_req_ready", i), req_ready, 0);
      check($sformatf("bp%0d_psel", i), psel, 0);
      tick();
    end
    check("bp_paddr_held", paddr, 32'h1A10_5000);
    rsp_ready = 1'b1; pready = 1'b0;
    tick();
    check("bp_done_rsp_valid", rsp_valid, 0);
    check("bp_done_req_ready", req_ready, 1);
    tick();
    req_valid = 1'b0;
    check("bp_next_psel", psel, 1);
    check("bp_next_paddr", paddr, 32'h1A10_6000);
    tick();
    tick();
    check("rst_mid_access_penable", penable, 1);

    // Reset during an ACCESS wait discards the transfer.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    pready = 1'b1;
    check("mid_rst_psel", psel, 0);
    check("mid_rst_penable", penable, 0);
    check("mid_rst_rsp_valid", rsp_valid, 0);
    check("mid_rst_req_ready", req_ready, 1);
    check("mid_rst_paddr", paddr, 0);
    for (int i = 1; i <= 3; i++) begin
      tick();
      check($sformatf("post_rst%0d_rsp_valid", i), rsp_valid, 0);
      check($sformatf("post_rst%0d_psel", i), psel, 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
